// File: rtl/wb_burst_master.sv
// ---------------------------------------------------------------------------
// wb_burst_master
//
// Wishbone B3 initiator. A single command (start address, beat count,
// direction, byte select) becomes one incrementing-burst bus cycle
// (CTI 010 on every beat except the last, which carries 111).
// Write data is pulled from a valid/ready stream through a one-word buffer.
// Read data is pushed out as a valid-only stream one cycle after each ack.
//
// Ports
//   wb_clk, wb_rst        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_we                1 = write burst, 0 = read burst
//   cmd_adr               start byte address (low lane bits ignored)
//   cmd_len               beats - 1
//   cmd_sel               byte select applied to every beat
//   wr_valid/wr_ready     write word handshake, wr_data payload
//   rd_valid, rd_data     read word stream (no backpressure)
//   done, err             one-cycle completion / abort pulses
//   wb_*                  Wishbone B3 initiator interface
// ---------------------------------------------------------------------------
module wb_burst_master #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int LEN_W  = 8,
    parameter int TO_CYC = 1023
) (
    input  logic              wb_clk,
    input  logic              wb_rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_adr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DW/8-1:0]   cmd_sel,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DW-1:0]     wr_data,

    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,

    output logic              done,
    output logic              err,

    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    input  logic [DW-1:0]     wb_dat_i,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_END
    } state_t;

    state_t             state;
    logic               we_r;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W:0]     fetch_left;
    logic [DW-1:0]      wbuf;
    logic               wbuf_full;
    logic [31:0]        to_cnt;

    logic               stb;
    logic               ack_ok;
    logic               err_hit;
    logic               to_hit;
    logic               wr_fire;

    // A read strobes for the whole cycle; a write only strobes while the
    // buffer holds a word, so an empty buffer shows up as a master wait state.
    assign stb      = wb_cyc_o && (!we_r || wbuf_full);
    assign wb_stb_o = stb;

    // Responder signals only count while strobing; err dominates ack.
    assign err_hit  = stb && wb_err_i;
    assign ack_ok   = stb && wb_ack_i && !wb_err_i;

    // Timeout fires on the cycle the wait count would reach TO_CYC.
    assign to_hit   = (TO_CYC != 0) && stb && !wb_ack_i && !wb_err_i &&
                      (to_cnt == 32'(TO_CYC - 1));

    // A new word may enter the buffer when it is empty or is being drained
    // by an ack this very cycle; never fetch beyond the burst length.
    assign wr_ready = (state == ST_BUS) && we_r && (fetch_left != '0) &&
                      (!wbuf_full || ack_ok);
    assign wr_fire  = wr_valid && wr_ready;

    // CTI is derived from the remaining count, so it is held during waits.
    assign wb_cti_o = !wb_cyc_o           ? 3'b000 :
                      (remaining == '0)   ? 3'b111 : 3'b010;
    assign wb_bte_o = 2'b00;
    assign wb_dat_o = wbuf;
    assign wb_we_o  = we_r;

    // Burst controller: command capture, beat accounting, write buffer,
    // read capture, timeout and the completion/abort pulses.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b0;
            we_r       <= 1'b0;
            remaining  <= '0;
            fetch_left <= '0;
            wbuf       <= '0;
            wbuf_full  <= 1'b0;
            to_cnt     <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            wb_adr_o   <= '0;
            wb_sel_o   <= '0;
            wb_cyc_o   <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;

            if (wr_fire) begin
                wbuf       <= wr_data;
                wbuf_full  <= 1'b1;
                fetch_left <= fetch_left - 1'b1;
            end else if (ack_ok) begin
                wbuf_full  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready  <= 1'b0;
                        we_r       <= cmd_we;
                        wb_adr_o   <= cmd_adr & ~(AW'(SW - 1));
                        wb_sel_o   <= cmd_sel;
                        remaining  <= cmd_len;
                        fetch_left <= cmd_we ? ({1'b0, cmd_len} + 1'b1) : '0;
                        wbuf_full  <= 1'b0;
                        to_cnt     <= '0;
                        wb_cyc_o   <= 1'b1;
                        state      <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    // The wait counter only runs while strobing unanswered.
                    if (!stb || ack_ok) begin
                        to_cnt <= '0;
                    end else if (TO_CYC != 0) begin
                        to_cnt <= to_cnt + 32'd1;
                    end

                    if (err_hit || to_hit) begin
                        wb_cyc_o <= 1'b0;
                        err      <= 1'b1;
                        state    <= ST_END;
                    end else if (ack_ok) begin
                        wb_adr_o <= wb_adr_o + AW'(SW);
                        if (!we_r) begin
                            rd_data  <= wb_dat_i;
                            rd_valid <= 1'b1;
                        end
                        if (remaining == '0) begin
                            wb_cyc_o <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_END;
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end

                ST_END: begin
                    // One idle bus cycle between bursts; drop any leftover
                    // buffered word from an aborted write.
                    wbuf_full  <= 1'b0;
                    fetch_left <= '0;
                    to_cnt     <= '0;
                    cmd_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end

                default: begin
                    wb_cyc_o <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// ---------------------------------------------------------------------------
// tb_wb_burst_master
//
// Bench for wb_burst_master. A behavioural Wishbone responder runs on the
// falling edge: it checks address/CTI/write data of every beat it answers,
// invents read data and pushes it to a scoreboard queue that is drained when
// rd_valid appears. Write words are pushed to a queue at the moment the
// handshake is known to happen and popped when the responder acks the beat.
// ---------------------------------------------------------------------------
module tb_wb_burst_master;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int LEN_W  = 8;
    localparam int TO_CYC = 16;

    logic              wb_clk = 1'b0;
    logic              wb_rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_we = 1'b0;
    logic [AW-1:0]     cmd_adr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DW/8-1:0]   cmd_sel = '0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [DW-1:0]     wr_data = 32'hA000_0000;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic              done;
    logic              err;
    logic [AW-1:0]     wb_adr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW-1:0]     wb_dat_i = '0;
    logic [DW/8-1:0]   wb_sel_o;
    logic              wb_we_o;
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_ack_i = 1'b0;
    logic              wb_err_i = 1'b0;

    always #5 wb_clk = ~wb_clk;

    wb_burst_master #(
        .AW(AW), .DW(DW), .LEN_W(LEN_W), .TO_CYC(TO_CYC)
    ) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .err(err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cti_o(wb_cti_o),
        .wb_bte_o(wb_bte_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    int total = 0;
    int bad   = 0;

    // Expected value for an empty queue; never equals a 32-bit observation.
    localparam logic [63:0] NONE = 64'h1_0000_0000;

    logic [31:0] rdq[$];
    logic [31:0] wrq[$];

    int          beat, burst_len, err_beat;
    bit          never_ack, both_mode, burst_we;
    logic [31:0] base_adr;
    int          wr_mode;
    int          rd_cnt, done_cnt, err_cnt, wr_taken, cyc_cycles;
    int          stb_first, err_at, cyc_n;
    bit          prev_end, fired;

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Responder, write-stream driver and output monitor, all on the
    // falling edge so everything is sampled half a cycle from the DUT edge.
    always @(negedge wb_clk) begin
        cyc_n++;
        if (wb_rst) begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            fired    = 1'b0;
            prev_end = 1'b0;
        end else begin
            if (fired) wr_data = wr_data + 32'h0101_0001;
            fired = 1'b0;

            if (prev_end) checkOutput("cmd_ready_after_end", 64'(cmd_ready), 64'd1);
            prev_end = done || err;

            if (rd_valid) begin
                rd_cnt++;
                checkOutput("rd_data", 64'(rd_data),
                            (rdq.size() > 0) ? 64'(rdq.pop_front()) : NONE);
            end
            if (done) begin
                done_cnt++;
                checkOutput("cyc_low_at_done", 64'(wb_cyc_o), 64'd0);
            end
            if (err) begin
                err_cnt++;
                err_at = cyc_n;
                checkOutput("cyc_low_at_err", 64'(wb_cyc_o), 64'd0);
            end
            if (wb_cyc_o) cyc_cycles++;

            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_cyc_o && wb_stb_o) begin
                if (stb_first < 0) stb_first = cyc_n;
                if (!never_ack) begin
                    checkOutput("adr", 64'(wb_adr_o), 64'(32'(base_adr + 32'(4 * beat))));
                    checkOutput("cti", 64'(wb_cti_o), (beat == burst_len) ? 64'd7 : 64'd2);
                    if (beat == err_beat) begin
                        wb_err_i = 1'b1;
                        wb_ack_i = both_mode;
                    end else begin
                        wb_ack_i = 1'b1;
                        if (burst_we) begin
                            checkOutput("wr_data", 64'(wb_dat_o),
                                        (wrq.size() > 0) ? 64'(wrq.pop_front()) : NONE);
                        end else begin
                            wb_dat_i = $urandom;
                            rdq.push_back(wb_dat_i);
                        end
                        beat++;
                    end
                end
            end

            case (wr_mode)
                1:       wr_valid = ~wr_valid;
                2:       wr_valid = 1'b1;
                default: wr_valid = 1'b0;
            endcase

            #1;
            if (wr_valid && wr_ready) begin
                wr_taken++;
                wrq.push_back(wr_data);
                fired = 1'b1;
            end
        end
    end

    // Configure the responder, clear the per-burst counters and hand one
    // command to the DUT.
    task automatic applyStimulus(input bit we, input logic [31:0] adr,
                                 input int len, input int ebeat,
                                 input bit nack, input bit both, input int wmode);
        int n;
        n = 0;
        @(negedge wb_clk);
        while (!cmd_ready && n < 50) begin
            @(negedge wb_clk);
            n++;
        end
        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        rdq.delete();
        wrq.delete();
        burst_we   = we;
        base_adr   = adr & 32'hFFFF_FFFC;
        burst_len  = len;
        err_beat   = ebeat;
        never_ack  = nack;
        both_mode  = both;
        beat       = 0;
        rd_cnt     = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        wr_taken   = 0;
        cyc_cycles = 0;
        stb_first  = -1;
        err_at     = -1;
        wr_mode    = wmode;
        cmd_we     = we;
        cmd_adr    = adr;
        cmd_len    = LEN_W'(len);
        cmd_sel    = 4'hF;
        cmd_valid  = 1'b1;
        @(negedge wb_clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic waitBurst(input int limit);
        int n;
        n = 0;
        while ((done_cnt + err_cnt) == 0 && n < limit) begin
            @(negedge wb_clk);
            n++;
        end
        checkOutput("burst_finished", 64'((done_cnt + err_cnt) != 0), 64'd1);
        repeat (3) @(negedge wb_clk);
    endtask

    initial begin
        int n;
        cyc_n = 0; wr_mode = 0; never_ack = 1'b0; err_beat = -1;
        burst_len = 0; base_adr = '0; beat = 0; stb_first = -1;

        // Reset values
        repeat (2) @(negedge wb_clk);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("rst_cyc", 64'(wb_cyc_o), 64'd0);
        checkOutput("rst_wr_ready", 64'(wr_ready), 64'd0);
        checkOutput("rst_done_err", 64'({done, err, rd_valid}), 64'd0);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        checkOutput("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // Read burst, 4 beats from 0x100
        applyStimulus(1'b0, 32'h100, 3, -1, 1'b0, 1'b0, 0);
        waitBurst(100);
        checkOutput("rd4_count", 64'(rd_cnt), 64'd4);
        checkOutput("rd4_done", 64'(done_cnt), 64'd1);
        checkOutput("rd4_err", 64'(err_cnt), 64'd0);
        checkOutput("rd4_cyc_cycles", 64'(cyc_cycles), 64'd4);

        // Write burst, 8 beats, wr_valid toggling
        applyStimulus(1'b1, 32'h2000, 7, -1, 1'b0, 1'b0, 1);
        waitBurst(200);
        repeat (4) @(negedge wb_clk);
        checkOutput("wr8_taken", 64'(wr_taken), 64'd8);
        checkOutput("wr8_beats", 64'(beat), 64'd8);
        checkOutput("wr8_done", 64'(done_cnt), 64'd1);
        checkOutput("wr8_left", 64'(wrq.size()), 64'd0);
        wr_mode = 0;

        // Single beat read
        applyStimulus(1'b0, 32'h3004, 0, -1, 1'b0, 1'b0, 0);
        waitBurst(100);
        checkOutput("rd1_count", 64'(rd_cnt), 64'd1);
        checkOutput("rd1_done", 64'(done_cnt), 64'd1);
        checkOutput("rd1_cyc_cycles", 64'(cyc_cycles), 64'd1);

        // Error on the third beat of a 6-beat read (unaligned start address)
        applyStimulus(1'b0, 32'h203, 5, 2, 1'b0, 1'b0, 0);
        waitBurst(100);
        checkOutput("e_rd_count", 64'(rd_cnt), 64'd2);
        checkOutput("e_err", 64'(err_cnt), 64'd1);
        checkOutput("e_done", 64'(done_cnt), 64'd0);

        // Ack and err together: err wins, no data
        applyStimulus(1'b0, 32'h400, 2, 0, 1'b0, 1'b1, 0);
        waitBurst(100);
        checkOutput("ae_rd_count", 64'(rd_cnt), 64'd0);
        checkOutput("ae_err", 64'(err_cnt), 64'd1);
        checkOutput("ae_done", 64'(done_cnt), 64'd0);

        // Timeout: responder never answers
        applyStimulus(1'b0, 32'h500, 3, -1, 1'b1, 1'b0, 0);
        waitBurst(100);
        checkOutput("to_err", 64'(err_cnt), 64'd1);
        checkOutput("to_done", 64'(done_cnt), 64'd0);
        checkOutput("to_latency", 64'(err_at - stb_first), 64'd16);
        never_ack = 1'b0;

        // Reset during beat 2 of a 4-beat write
        applyStimulus(1'b1, 32'h600, 3, -1, 1'b0, 1'b0, 2);
        n = 0;
        while (!(beat >= 1 && wb_cyc_o) && n < 50) begin
            @(negedge wb_clk);
            n++;
        end
        checkOutput("rst_mid_reached", 64'(beat >= 1), 64'd1);
        #2 wb_rst = 1'b1;
        #1;
        checkOutput("rst_mid_outs", 64'({wb_cyc_o, wb_stb_o, done, err}), 64'd0);
        wr_mode = 0;
        repeat (2) @(negedge wb_clk);
        wb_rst = 1'b0;
        applyStimulus(1'b0, 32'h40, 1, -1, 1'b0, 1'b0, 0);
        waitBurst(100);
        checkOutput("post_rst_rd", 64'(rd_cnt), 64'd2);
        checkOutput("post_rst_done", 64'(done_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
